// File: rtl/indexed_array_reg.sv
// DEPTH x WIDTH register file: one write port and one registered read port.
// Define INDEXED_ARRAY_REG_BYPASS_EN for write-first forwarding on same-index read/write.
module indexed_array_reg #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int IDX_W     = 2,
    parameter int DEFAULT   = 3,
    parameter int INIT_BASE = 1
) (
    input  logic [1:0]       clock_reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_index,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_oob
);

    localparam logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(DEFAULT);

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             wr_in_range;
    logic             rd_in_range;
    logic [WIDTH-1:0] rd_word;

    assign clk = clock_reset[0];
    assign rst = clock_reset[1];

    // Indices are widened so non-power-of-two depths compare correctly.
    assign wr_in_range = (32'(wr_index) < 32'(DEPTH));
    assign rd_in_range = (32'(rd_index) < 32'(DEPTH));

    function automatic logic [WIDTH-1:0] init_value(input int idx);
        return WIDTH'(INIT_BASE + idx);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= init_value(i);
            end
        end else if (wr_en && wr_in_range) begin
            entries[wr_index] <= wr_data;
        end
    end

    always_comb begin
        rd_word = DEFAULT_VAL;
        if (rd_in_range) begin
            rd_word = entries[rd_index];
        end
`ifdef INDEXED_ARRAY_REG_BYPASS_EN
        if (wr_en && wr_in_range && rd_in_range && (wr_index == rd_index)) begin
            rd_word = wr_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= DEFAULT_VAL;
            rd_valid <= 1'b0;
            rd_oob   <= 1'b0;
        end else begin
            rd_data  <= rd_en ? rd_word : DEFAULT_VAL;
            rd_valid <= rd_en;
            rd_oob   <= rd_en && !rd_in_range;
        end
    end

endmodule

// File: tb/tb_indexed_array_reg.sv
// Self-checking bench for indexed_array_reg: a DEPTH=4 and a DEPTH=3 instance share
// the same stimulus and are checked against an array-based reference model.
module tb_indexed_array_reg;

    localparam logic [3:0] DEF = 4'h3;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_index;
    logic [3:0] wr_data;
    logic       rd_en;
    logic [1:0] rd_index;

    logic [3:0] rd_data4, rd_data3;
    logic       rd_valid4, rd_valid3, rd_oob4, rd_oob3;
    logic [5:0] obs4, obs3;

    int checks   = 0;
    int failures = 0;

    int         depths [2] = '{4, 3};
    logic [3:0] model  [2][4];
    logic [5:0] exp_out [2];

    assign obs4 = {rd_data4, rd_valid4, rd_oob4};
    assign obs3 = {rd_data3, rd_valid3, rd_oob3};

    indexed_array_reg #(.WIDTH(4), .DEPTH(4), .IDX_W(2), .DEFAULT(3), .INIT_BASE(1)) dut4 (
        .clock_reset({rst, clk}),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .rd_en(rd_en), .rd_index(rd_index),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .rd_oob(rd_oob4)
    );

    indexed_array_reg #(.WIDTH(4), .DEPTH(3), .IDX_W(2), .DEFAULT(3), .INIT_BASE(1)) dut3 (
        .clock_reset({rst, clk}),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .rd_en(rd_en), .rd_index(rd_index),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .rd_oob(rd_oob3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) model[k][i] = 4'(1 + i);
            exp_out[k] = {DEF, 2'b00};
        end
    endtask

    // Apply one edge worth of inputs, advance the model, and return #1 after the edge.
    task automatic drive_edge(input logic we, input logic [1:0] wi, input logic [3:0] wd,
                              input logic re, input logic [1:0] ri);
        logic [3:0] v;
        wr_en = we; wr_index = wi; wr_data = wd; rd_en = re; rd_index = ri;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_out[k] = {DEF, 2'b00};
            end else begin
                if (!re) exp_out[k] = {DEF, 2'b00};
                else if (int'(ri) >= depths[k]) exp_out[k] = {DEF, 2'b11};
                else begin
                    v = model[k][ri];
`ifdef INDEXED_ARRAY_REG_BYPASS_EN
                    if (we && wi == ri) v = wd;
`endif
                    exp_out[k] = {v, 2'b10};
                end
                if (we && int'(wi) < depths[k]) model[k][wi] = wd;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (obs4 !== {DEF, 2'b00}) begin
            failures++; $display("[TB] FAIL reset_hold got=%h exp=%h", obs4, {DEF, 2'b00});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 2'd0, 4'h0, 1'b0, 2'd0);
            checks++;
            if (obs4 !== {DEF, 2'b00}) begin
                failures++; $display("[TB] FAIL idle_%0d got=%h exp=%h", i, obs4, {DEF, 2'b00});
            end
        end
    endtask

    task automatic test_seq_read();
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'(i));
            checks++;
            if (obs4 !== {4'(i + 1), 2'b10}) begin
                failures++; $display("[TB] FAIL init_read_%0d got=%h exp=%h", i, obs4, {4'(i + 1), 2'b10});
            end
        end
    endtask

    task automatic test_write_read();
        logic [3:0] same_edge;
`ifdef INDEXED_ARRAY_REG_BYPASS_EN
        same_edge = 4'hF;
`else
        same_edge = 4'h4;
`endif
        drive_edge(1'b1, 2'd1, 4'hA, 1'b0, 2'd0);
        drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'd1);
        checks++;
        if (obs4 !== {4'hA, 2'b10}) begin
            failures++; $display("[TB] FAIL wr_then_rd got=%h exp=%h", obs4, {4'hA, 2'b10});
        end
        drive_edge(1'b1, 2'd3, 4'hF, 1'b1, 2'd3);
        checks++;
        if (obs4 !== {same_edge, 2'b10}) begin
            failures++; $display("[TB] FAIL same_edge_rw got=%h exp=%h", obs4, {same_edge, 2'b10});
        end
        drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'd3);
        checks++;
        if (obs4 !== {4'hF, 2'b10}) begin
            failures++; $display("[TB] FAIL rd_after_same_edge got=%h exp=%h", obs4, {4'hF, 2'b10});
        end
    endtask

    task automatic test_out_of_range();
        drive_edge(1'b1, 2'd3, 4'h9, 1'b0, 2'd0);
        drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'd3);
        checks++;
        if (obs3 !== {DEF, 2'b11}) begin
            failures++; $display("[TB] FAIL oob_read got=%h exp=%h", obs3, {DEF, 2'b11});
        end
        checks++;
        if (obs4 !== {4'h9, 2'b10}) begin
            failures++; $display("[TB] FAIL depth4_idx3 got=%h exp=%h", obs4, {4'h9, 2'b10});
        end
        drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'd2);
        checks++;
        if (obs3 !== {4'h3, 2'b10}) begin
            failures++; $display("[TB] FAIL depth3_idx2 got=%h exp=%h", obs3, {4'h3, 2'b10});
        end
        drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'd1);
        checks++;
        if (obs3 !== {4'hA, 2'b10}) begin
            failures++; $display("[TB] FAIL depth3_idx1 got=%h exp=%h", obs3, {4'hA, 2'b10});
        end
    endtask

    task automatic test_async_reset();
        drive_edge(1'b1, 2'd0, 4'h7, 1'b0, 2'd0);
        drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'd0);
        checks++;
        if (obs4 !== {4'h7, 2'b10}) begin
            failures++; $display("[TB] FAIL pre_reset_rd got=%h exp=%h", obs4, {4'h7, 2'b10});
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs4 !== {DEF, 2'b00}) begin
            failures++; $display("[TB] FAIL async_reset got=%h exp=%h", obs4, {DEF, 2'b00});
        end
        #1;
        rst = 1'b0;
        drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'd0);
        checks++;
        if (obs4 !== {4'h1, 2'b10}) begin
            failures++; $display("[TB] FAIL post_reset_idx0 got=%h exp=%h", obs4, {4'h1, 2'b10});
        end
        drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'd3);
        checks++;
        if (obs4 !== {4'h4, 2'b10}) begin
            failures++; $display("[TB] FAIL post_reset_idx3 got=%h exp=%h", obs4, {4'h4, 2'b10});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b1, 2'd2, 4'($urandom), 1'b1, 2'd2);
            checks++;
            if (obs4 !== exp_out[0]) begin
                failures++; $display("[TB] FAIL b2b_%0d got=%h exp=%h", i, obs4, exp_out[0]);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                checks++;
                if (obs4 !== {DEF, 2'b00} || obs3 !== {DEF, 2'b00}) begin
                    failures++; $display("[TB] FAIL rand_async_rst got=%h/%h exp=%h", obs4, obs3, {DEF, 2'b00});
                end
                hold = $urandom_range(1, 3);
                for (int h = 0; h < hold; h++) begin
                    drive_edge(1'b1, 2'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
                end
                rst = 1'b0;
            end
            drive_edge(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
            checks++;
            if (obs4 !== exp_out[0] || obs3 !== exp_out[1]) begin
                failures++;
                $display("[TB] FAIL rand_%0d got=%h/%h exp=%h/%h", n, obs4, obs3, exp_out[0], exp_out[1]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b0, 2'd0, 4'h0, 1'b1, 2'(i));
            checks++;
            if (obs4 !== exp_out[0] || obs3 !== exp_out[1]) begin
                failures++;
                $display("[TB] FAIL final_rd_%0d got=%h/%h exp=%h/%h", i, obs4, obs3, exp_out[0], exp_out[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_index = 2'd0; wr_data = 4'h0;
        rd_en = 1'b0; rd_index = 2'd0;
        model_reset();
        #12;
        test_reset();
        test_seq_read();
        test_write_read();
        test_out_of_range();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
